// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
// Covers the FSM state encoding, completion causes and byte-enable patterns.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    FLT  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MISS = 2'b01;
  localparam logic [1:0] CAUSE_PROT = 2'b10;
  localparam logic [1:0] CAUSE_BUS  = 2'b11;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_lane.sv
// Combinational byte-lane steering for a 16-bit bus: byte enables, write-byte
// replication, and read-byte extraction with zero extension.
module mem_lane
  import mem_seq_pkg::*;
#(
  parameter int RV = 16
) (
  input  logic [RV-1:0]   wdata,
  input  logic            byte_acc,
  input  logic            byte_hi,
  input  logic [RV/8-1:0] rd_be,
  input  logic [RV-1:0]   bus_rdata,
  output logic [RV/8-1:0] be,
  output logic [RV-1:0]   lane_wdata,
  output logic [RV-1:0]   lane_rdata
);

  always_comb begin
    be         = BE_WORD;
    lane_wdata = wdata;
    if (byte_acc) begin
      be         = byte_hi ? BE_HI : BE_LO;
      lane_wdata = {(RV/8){wdata[7:0]}};
    end
  end

  // Read extraction keys off the enables latched for the access in flight.
  always_comb begin
    lane_rdata = bus_rdata;
    case (rd_be)
      BE_HI:   lane_rdata = {{(RV-8){1'b0}}, bus_rdata[15:8]};
      BE_LO:   lane_rdata = {{(RV-8){1'b0}}, bus_rdata[7:0]};
      default: lane_rdata = bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_seq.sv
// Memory access sequencer downstream of the mmu: completes faulting accesses
// directly, otherwise runs a req/ack bus handshake with a timeout.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int RV      = 16,
  parameter int PA      = RV,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                is_pc,
  input  logic                is_read,
  input  logic                is_write,
  input  logic                byte_acc,
  input  logic                byte_hi,
  input  logic [RV-1:0]       wdata,
  input  logic [PA-RV/16-1:0] addrp,
  input  logic                mmu_miss_fault,
  input  logic                mmu_prot_fault,
  output logic                mmu_fault,
  output logic                ack,
  output logic [RV-1:0]       rdata,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic                bus_req,
  output logic                bus_we,
  output logic [PA-RV/16-1:0] bus_addr,
  output logic [RV/8-1:0]     bus_be,
  output logic [RV-1:0]       bus_wdata,
  input  logic                bus_ack,
  input  logic [RV-1:0]       bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mmu_fault_q, mmu_fault_d;
  logic                  ack_q, ack_d;
  logic [RV-1:0]         rdata_q, rdata_d;
  logic                  fault_q, fault_d;
  logic [1:0]            cause_q, cause_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [PA-RV/16-1:0]   bus_addr_q, bus_addr_d;
  logic [RV/8-1:0]       bus_be_q, bus_be_d;
  logic [RV-1:0]         bus_wdata_q, bus_wdata_d;

  logic [RV/8-1:0]       lane_be;
  logic [RV-1:0]         lane_wdata;
  logic [RV-1:0]         lane_rdata;

  mem_lane #(.RV(RV)) u_lane (
    .wdata      (wdata),
    .byte_acc   (byte_acc),
    .byte_hi    (byte_hi),
    .rd_be      (bus_be_q),
    .bus_rdata  (bus_rdata),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .lane_rdata (lane_rdata)
  );

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mmu_fault_d = 1'b0;
    ack_d       = 1'b0;
    rdata_d     = '0;
    fault_d     = 1'b0;
    cause_d     = CAUSE_NONE;
    bus_req_d   = 1'b0;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (mmu_miss_fault || mmu_prot_fault) begin
            state_d     = FLT;
            mmu_fault_d = 1'b1;
            ack_d       = 1'b1;
            fault_d     = 1'b1;
            cause_d     = mmu_miss_fault ? CAUSE_MISS : CAUSE_PROT;
          end else if (!(is_pc || is_read || is_write)) begin
            state_d = DONE;
            ack_d   = 1'b1;
          end else begin
            state_d     = BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = is_write & ~is_pc;
            bus_addr_d  = addrp;
            bus_be_d    = lane_be;
            bus_wdata_d = lane_wdata;
          end
        end
      end
      BUS: begin
        // An ack arriving on the last allowed cycle still wins over the timeout.
        if (bus_ack) begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = bus_we_q ? '0 : lane_rdata;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = DONE;
          ack_d   = 1'b1;
          fault_d = 1'b1;
          cause_d = CAUSE_BUS;
        end else begin
          bus_req_d = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      FLT:     state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mmu_fault_q <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      cause_q     <= CAUSE_NONE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= BE_NONE;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mmu_fault_q <= mmu_fault_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign mmu_fault   = mmu_fault_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_mem_seq.sv
// Randomized self-checking bench for mem_seq; the bench plays CPU, mmu and
// bus slave and compares every access against a behavioural access model.
module tb_mem_seq;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, is_pc, is_read, is_write, byte_acc, byte_hi;
  logic [15:0] wdata;
  logic [14:0] addrp;
  logic        mmu_miss_fault, mmu_prot_fault;
  logic        mmu_fault, ack, fault;
  logic [15:0] rdata;
  logic [1:0]  fault_cause;
  logic        bus_req, bus_we;
  logic [14:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic pc, rd, wr, byt, hi, miss, prot;
    logic [15:0] wdata;
    logic [14:0] addr;
    int          delay;
    logic [15:0] brdata;
  } req_t;

  typedef struct {
    int          lat;
    int          breq_cycles;
    int          mmu_cycles;
    logic [1:0]  be;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    logic        bus_stable;
    logic        ack_after;
    logic        timed_out;
  } obs_t;

  mem_seq #(.RV(16), .PA(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .is_pc(is_pc), .is_read(is_read),
    .is_write(is_write), .byte_acc(byte_acc), .byte_hi(byte_hi), .wdata(wdata),
    .addrp(addrp), .mmu_miss_fault(mmu_miss_fault), .mmu_prot_fault(mmu_prot_fault),
    .mmu_fault(mmu_fault), .ack(ack), .rdata(rdata), .fault(fault),
    .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Access-level reference: what the CPU and bus should observe for one request.
  function automatic obs_t model(input req_t r);
    obs_t e;
    e = '{default: '0};
    e.bus_stable = 1'b1;
    if (r.miss || r.prot) begin
      e.lat = 1; e.fault = 1'b1; e.mmu_cycles = 1;
      e.cause = r.miss ? 2'b01 : 2'b10;
    end else if (!(r.pc || r.rd || r.wr)) begin
      e.lat = 1;
    end else begin
      e.we    = r.wr && !r.pc;
      e.addr  = r.addr;
      e.be    = !r.byt ? 2'b11 : (r.hi ? 2'b10 : 2'b01);
      e.wdata = r.byt ? {r.wdata[7:0], r.wdata[7:0]} : r.wdata;
      if (r.delay <= TIMEOUT) begin
        e.breq_cycles = r.delay + 1;
        e.lat = r.delay + 2;
        if (e.we)       e.rdata = 16'h0000;
        else if (r.byt) e.rdata = (r.brdata >> (r.hi ? 8 : 0)) & 16'h00FF;
        else            e.rdata = r.brdata;
      end else begin
        e.breq_cycles = TIMEOUT + 1;
        e.lat = TIMEOUT + 2;
        e.fault = 1'b1;
        e.cause = 2'b11;
      end
    end
    return e;
  endfunction

  // Drives one request and acts as bus slave; called at #1 after a posedge in IDLE.
  task automatic do_access(input req_t r, output obs_t o);
    bit done;
    o = '{default: '0};
    o.bus_stable = 1'b1;
    done = 0;
    req = 1'b1; is_pc = r.pc; is_read = r.rd; is_write = r.wr;
    byte_acc = r.byt; byte_hi = r.hi; wdata = r.wdata; addrp = r.addr;
    mmu_miss_fault = r.miss; mmu_prot_fault = r.prot;
    bus_ack = 1'b0;
    for (int k = 1; k <= TIMEOUT + 10 && !done; k++) begin
      @(posedge clk); #1;
      mmu_miss_fault = 1'($urandom); mmu_prot_fault = 1'($urandom);
      if (mmu_fault) o.mmu_cycles++;
      if (bus_req) begin
        if (o.breq_cycles == 0) begin
          o.be = bus_be; o.we = bus_we; o.addr = bus_addr; o.wdata = bus_wdata;
        end else if (bus_be !== o.be || bus_we !== o.we || bus_addr !== o.addr ||
                     bus_wdata !== o.wdata) begin
          o.bus_stable = 1'b0;
        end
        if (o.breq_cycles == r.delay) begin
          bus_ack = 1'b1; bus_rdata = r.brdata;
        end else begin
          bus_ack = 1'b0; bus_rdata = 16'($urandom);
        end
        o.breq_cycles++;
      end else begin
        bus_ack = 1'($urandom); bus_rdata = 16'($urandom);
      end
      if (ack) begin
        o.lat = k; o.rdata = rdata; o.fault = fault; o.cause = fault_cause;
        done = 1;
      end
    end
    if (!done) o.timed_out = 1'b1;
    req = 1'b0; mmu_miss_fault = 1'b0; mmu_prot_fault = 1'b0;
    bus_ack = 1'($urandom);
    @(posedge clk); #1;
    o.ack_after = ack;
    if (mmu_fault) o.mmu_cycles++;
    bus_ack = 1'b0;
  endtask

  function automatic req_t blank_req();
    req_t r;
    r = '{default: '0};
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; is_pc = 0; is_read = 0; is_write = 0;
    byte_acc = 0; byte_hi = 0; wdata = '0; addrp = '0;
    mmu_miss_fault = 0; mmu_prot_fault = 0; bus_ack = 0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if ({bus_req, ack, fault, mmu_fault} !== 4'b0) begin tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus_req, ack, fault, mmu_fault}); end
    tests_run++; if (fault_cause !== 2'b00) begin tests_failed++;
      $display("[TB] FAIL reset_cause: got %b expected 00", fault_cause); end
    tests_run++; if (rdata !== 16'h0) begin tests_failed++;
      $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata); end
    tests_run++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin tests_failed++;
      $display("[TB] FAIL reset_bus: got %b/%b/%h/%h expected zeros", bus_we, bus_be, bus_addr, bus_wdata); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_read();
    req_t r; obs_t o;
    r = blank_req(); r.rd = 1; r.addr = 15'h1234; r.delay = 0; r.brdata = 16'hBEEF;
    do_access(r, o);
    tests_run++; if (o.breq_cycles !== 1 || o.lat !== 2) begin tests_failed++;
      $display("[TB] FAIL word_read_timing: got breq=%0d lat=%0d expected 1/2", o.breq_cycles, o.lat); end
    tests_run++; if (o.be !== 2'b11 || o.we !== 1'b0 || o.addr !== 15'h1234) begin tests_failed++;
      $display("[TB] FAIL word_read_bus: got be=%b we=%b addr=%h expected 11/0/1234", o.be, o.we, o.addr); end
    tests_run++; if (o.rdata !== 16'hBEEF || o.fault !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL word_read_data: got %h fault=%b expected BEEF/0", o.rdata, o.fault); end
    tests_run++; if (o.ack_after !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL word_read_ack_width: got %b expected 0", o.ack_after); end
  endtask

  task automatic test_byte_write();
    req_t r; obs_t o;
    r = blank_req(); r.wr = 1; r.byt = 1; r.hi = 1; r.wdata = 16'h00A5;
    r.addr = 15'h0042; r.delay = 1; r.brdata = 16'h1357;
    do_access(r, o);
    tests_run++; if (o.be !== 2'b10 || o.we !== 1'b1 || o.wdata !== 16'hA5A5) begin tests_failed++;
      $display("[TB] FAIL byte_write_bus: got be=%b we=%b wdata=%h expected 10/1/A5A5", o.be, o.we, o.wdata); end
    tests_run++; if (o.fault !== 1'b0 || o.rdata !== 16'h0 || o.lat !== 3) begin tests_failed++;
      $display("[TB] FAIL byte_write_done: got fault=%b rdata=%h lat=%0d expected 0/0000/3", o.fault, o.rdata, o.lat); end
  endtask

  task automatic test_faults();
    req_t r; obs_t o;
    r = blank_req(); r.rd = 1; r.miss = 1; r.prot = 1; r.addr = 15'h0777;
    do_access(r, o);
    tests_run++; if (o.lat !== 1 || o.mmu_cycles !== 1 || o.fault !== 1'b1 || o.cause !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL miss_fault: got lat=%0d mmu=%0d fault=%b cause=%b expected 1/1/1/01", o.lat, o.mmu_cycles, o.fault, o.cause); end
    tests_run++; if (o.breq_cycles !== 0) begin tests_failed++;
      $display("[TB] FAIL miss_no_bus: got %0d bus cycles expected 0", o.breq_cycles); end
    r = blank_req(); r.wr = 1; r.prot = 1;
    do_access(r, o);
    tests_run++; if (o.cause !== 2'b10 || o.fault !== 1'b1 || o.breq_cycles !== 0) begin tests_failed++;
      $display("[TB] FAIL prot_fault: got cause=%b fault=%b breq=%0d expected 10/1/0", o.cause, o.fault, o.breq_cycles); end
  endtask

  task automatic test_byte_read_wait();
    req_t r; obs_t o;
    r = blank_req(); r.rd = 1; r.byt = 1; r.hi = 0; r.delay = 3; r.brdata = 16'h7F80;
    do_access(r, o);
    tests_run++; if (o.breq_cycles !== 4 || o.lat !== 5) begin tests_failed++;
      $display("[TB] FAIL byte_read_wait_timing: got breq=%0d lat=%0d expected 4/5", o.breq_cycles, o.lat); end
    tests_run++; if (o.rdata !== 16'h0080 || o.be !== 2'b01 || !o.bus_stable) begin tests_failed++;
      $display("[TB] FAIL byte_read_wait_data: got %h be=%b stable=%b expected 0080/01/1", o.rdata, o.be, o.bus_stable); end
  endtask

  task automatic test_timeout();
    req_t r; obs_t o;
    r = blank_req(); r.rd = 1; r.delay = 99; r.addr = 15'h0100;
    do_access(r, o);
    tests_run++; if (o.breq_cycles !== TIMEOUT + 1) begin tests_failed++;
      $display("[TB] FAIL timeout_breq: got %0d expected %0d", o.breq_cycles, TIMEOUT + 1); end
    tests_run++; if (o.fault !== 1'b1 || o.cause !== 2'b11 || o.mmu_cycles !== 0) begin tests_failed++;
      $display("[TB] FAIL timeout_result: got fault=%b cause=%b mmu=%0d expected 1/11/0", o.fault, o.cause, o.mmu_cycles); end
    r.delay = TIMEOUT; r.brdata = 16'h4321;
    do_access(r, o);
    tests_run++; if (o.fault !== 1'b0 || o.rdata !== 16'h4321 || o.breq_cycles !== TIMEOUT + 1) begin tests_failed++;
      $display("[TB] FAIL timeout_last_ack: got fault=%b rdata=%h breq=%0d expected 0/4321/%0d", o.fault, o.rdata, o.breq_cycles, TIMEOUT + 1); end
  endtask

  task automatic test_noop_and_ignore();
    req_t r; obs_t o;
    bit stray;
    r = blank_req(); r.byt = 1; r.addr = 15'h7FFF;
    do_access(r, o);
    tests_run++; if (o.lat !== 1 || o.fault !== 1'b0 || o.breq_cycles !== 0 || o.mmu_cycles !== 0) begin tests_failed++;
      $display("[TB] FAIL noop: got lat=%0d fault=%b breq=%0d mmu=%0d expected 1/0/0/0", o.lat, o.fault, o.breq_cycles, o.mmu_cycles); end
    stray = 0;
    bus_ack = 1'b1; mmu_miss_fault = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack || bus_req || mmu_fault) stray = 1;
    end
    bus_ack = 1'b0; mmu_miss_fault = 1'b0;
    tests_run++; if (stray !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL idle_ignore: got activity=%b expected 0", stray); end
    r = blank_req(); r.pc = 1; r.wr = 1; r.addr = 15'h7FFF; r.delay = 0; r.brdata = 16'hC0DE;
    do_access(r, o);
    tests_run++; if (o.addr !== 15'h7FFF || o.we !== 1'b0 || o.rdata !== 16'hC0DE) begin tests_failed++;
      $display("[TB] FAIL all_ones_fetch: got addr=%h we=%b rdata=%h expected 7FFF/0/C0DE", o.addr, o.we, o.rdata); end
  endtask

  task automatic test_reset_mid_access();
    req_t r; obs_t o;
    bit seen, stray;
    seen = 0; stray = 0;
    req = 1'b1; is_pc = 0; is_read = 1; is_write = 0; byte_acc = 0; byte_hi = 0;
    addrp = 15'h0ABC; bus_ack = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus_req) seen = 1;
    end
    #1 reset = 1'b0;
    #1;
    tests_run++; if (!seen || bus_req !== 1'b0 || ack !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL reset_mid: got seen=%b bus_req=%b ack=%b expected 1/0/0", seen, bus_req, ack); end
    req = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (ack || bus_req) stray = 1; end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    if (ack || bus_req) stray = 1;
    tests_run++; if (stray !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL reset_mid_quiet: got activity=%b expected 0", stray); end
    r = blank_req(); r.rd = 1; r.addr = 15'h0ABD; r.delay = 0; r.brdata = 16'h5AA5;
    do_access(r, o);
    tests_run++; if (o.lat !== 2 || o.rdata !== 16'h5AA5 || o.fault !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL reset_mid_recover: got lat=%0d rdata=%h fault=%b expected 2/5AA5/0", o.lat, o.rdata, o.fault); end
  endtask

  task automatic test_random();
    req_t r; obs_t o, e;
    for (int n = 0; n < 40; n++) begin
      r = blank_req();
      r.pc = 1'($urandom); r.rd = 1'($urandom); r.wr = 1'($urandom);
      r.byt = 1'($urandom); r.hi = 1'($urandom);
      r.miss = ($urandom_range(0, 7) == 0); r.prot = ($urandom_range(0, 7) == 0);
      r.wdata = 16'($urandom); r.brdata = 16'($urandom);
      r.addr = ($urandom_range(0, 9) == 0) ? 15'h7FFF : 15'($urandom);
      case ($urandom_range(0, 9))
        0:       r.delay = 99;
        1:       r.delay = TIMEOUT;
        default: r.delay = $urandom_range(0, 4);
      endcase
      e = model(r);
      do_access(r, o);
      tests_run++; if (o.timed_out || o.lat !== e.lat || o.breq_cycles !== e.breq_cycles) begin tests_failed++;
        $display("[TB] FAIL rand%0d_timing: got lat=%0d breq=%0d expected %0d/%0d", n, o.lat, o.breq_cycles, e.lat, e.breq_cycles); end
      tests_run++; if (o.fault !== e.fault || o.cause !== e.cause || o.mmu_cycles !== e.mmu_cycles) begin tests_failed++;
        $display("[TB] FAIL rand%0d_status: got fault=%b cause=%b mmu=%0d expected %b/%b/%0d", n, o.fault, o.cause, o.mmu_cycles, e.fault, e.cause, e.mmu_cycles); end
      tests_run++; if (o.ack_after !== 1'b0) begin tests_failed++;
        $display("[TB] FAIL rand%0d_ack_width: got %b expected 0", n, o.ack_after); end
      if (e.breq_cycles > 0) begin
        tests_run++; if (o.be !== e.be || o.we !== e.we || o.addr !== e.addr || !o.bus_stable) begin tests_failed++;
          $display("[TB] FAIL rand%0d_bus: got be=%b we=%b addr=%h stable=%b expected %b/%b/%h/1", n, o.be, o.we, o.addr, o.bus_stable, e.be, e.we, e.addr); end
        if (e.we) begin
          tests_run++; if (o.wdata !== e.wdata) begin tests_failed++;
            $display("[TB] FAIL rand%0d_wdata: got %h expected %h", n, o.wdata, e.wdata); end
        end
        if (!e.fault) begin
          tests_run++; if (o.rdata !== e.rdata) begin tests_failed++;
            $display("[TB] FAIL rand%0d_rdata: got %h expected %h", n, o.rdata, e.rdata); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_faults();
    test_byte_read_wait();
    test_timeout();
    test_noop_and_ignore();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Memory access sequencer sitting directly downstream of the mmu.
- Takes the CPU access request together with the translated physical word address and the fault flags from the mmu.
- On a fault, sends the one-cycle `mmu_fault` strobe back to the mmu so it latches fault state, and completes the access with a fault.
- Otherwise runs a req/ack handshake on the external memory bus, with byte-lane steering and a bus-timeout error.

Parameters:
- RV, 16: CPU data width; bus data width equals RV.
- PA, RV: physical address width in bytes; the word address is [PA-1:RV/16].
- TIMEOUT, 15: maximum BUS-state cycles without bus_ack before a bus error; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  1  CPU access request; held with all qualifiers stable until the cycle ack=1.
- is_pc  in  1  instruction fetch (read).
- is_read  in  1  data read.
- is_write  in  1  data write.
- byte  in  1  byte access; 0 = full word.
- byte_hi  in  1  selects upper byte lane when byte=1.
- wdata  in  RV  write data.
- addrp  in  PA-RV/16  physical word address from the mmu.
- mmu_miss_fault  in  1  mmu invalid-entry fault, combinational.
- mmu_prot_fault  in  1  mmu write-protect fault, combinational.
- mmu_fault  out  1  one-cycle strobe to the mmu to latch fault address/type.
- ack  out  1  one-cycle access completion.
- rdata  out  RV  read data; valid while ack=1.
- fault  out  1  qualifies ack: the access failed.
- fault_cause  out  2  00 none, 01 miss, 10 prot, 11 bus timeout; valid with ack.
- bus_req  out  1  external bus request.
- bus_we  out  1  bus write.
- bus_addr  out  PA-RV/16  bus word address.
- bus_be  out  RV/8  byte enables.
- bus_wdata  out  RV  bus write data.
- bus_ack  in  1  bus completion; read data valid in the same cycle.
- bus_rdata  in  RV  bus read data.

Behaviour:
- Reset values (asynchronous, on reset=0): state=IDLE; all outputs 0, including bus_req, ack, fault, fault_cause, mmu_fault, rdata. Reset mid-access drops bus_req immediately and abandons the access; no ack is issued.
- FSM states: IDLE, BUS, FLT, DONE. All outputs are registered.
- IDLE, req=1, sampled at the posedge:
  - miss=1 → FLT, cause=01. Miss has priority over prot.
  - else prot=1 → FLT, cause=10.
  - else none of is_pc/is_read/is_write → DONE, no bus access, fault=0.
  - else → BUS. Latch bus_addr=addrp and bus_we=is_write&~is_pc.
- Byte enables and write data (RV=16):
  - Word access: bus_be=11.
  - Byte access: bus_be=10 if byte_hi else 01.
  - Byte write: replicate wdata[7:0] into both lanes of bus_wdata.
  - Word write: bus_wdata=wdata.
- FLT (one cycle): mmu_fault=1, ack=1, fault=1, fault_cause held, then → IDLE. No bus activity.
- BUS: bus_req=1, with bus_addr/we/be/wdata stable.
  - Timeout counter, width $clog2(TIMEOUT+1), starts at 0 on entry and increments each cycle without bus_ack.
  - bus_ack=1 → latch read data, drop bus_req, → DONE, fault=0.
    - Word read: rdata=bus_rdata.
    - Byte read: rdata={0, selected byte}, zero-extended.
    - Write: rdata=0.
  - bus_ack=1 in the same cycle the counter reaches TIMEOUT: the ack wins and completes normally.
  - counter==TIMEOUT with no ack → drop bus_req, → DONE, fault=1, cause=11. mmu_fault is not strobed for bus errors.
- DONE (one cycle): ack=1, then → IDLE. The CPU changes or deasserts req at the same edge, so IDLE evaluates a fresh request in the next cycle.
- Latency:
  - Fault: ack in cycle 1 after req.
  - Zero-wait bus: bus_req in cycle 1, ack in cycle 2.
  - Each bus wait state adds one cycle.
- Boundary and ignore rules:
  - bus_ack outside BUS is ignored.
  - mmu fault inputs are ignored outside IDLE.
  - req is ignored in FLT/DONE.
  - addrp is passed through unmodified, including the all-ones address.

Decomposition:
- Package mem_seq_pkg:
  - state enum (IDLE/BUS/FLT/DONE);
  - cause constants (CAUSE_NONE/MISS/PROT/BUS);
  - byte-enable constants.
- Sub-module mem_lane: combinational byte-lane steering, covering the be/wdata replication and the read-byte extract/zero-extend.
- FSM and timeout counter stay in mem_seq.

Test Plan:
- Word read at addrp=15'h1234; bus_ack in the first BUS cycle with bus_rdata=16'hBEEF → bus_req for 1 cycle with bus_be=11, bus_we=0; ack in cycle 2 with rdata=16'hBEEF, fault=0.
- Byte write, byte_hi=1, wdata=16'h00A5 → bus_be=10, bus_wdata=16'hA5A5, bus_we=1; ack with fault=0, rdata=0.
- req with miss=1 and prot=1 → FLT: cycle 1 shows mmu_fault=1, ack=1, fault=1, cause=01; bus_req never asserts. With prot only → cause=10.
- Byte read, byte_hi=0, bus_ack delayed 3 cycles, bus_rdata=16'h7F80 → bus_req held 4 cycles; ack with rdata=16'h0080.
- TIMEOUT=15 and bus_ack never asserted → bus_req high exactly 16 cycles; ack with fault=1, cause=11, mmu_fault=0. Repeat with bus_ack arriving on the final cycle → normal completion, fault=0.
- Assert reset=0 while bus_req=1 → bus_req=0 asynchronously with no ack; after release the FSM is in IDLE and a new read completes normally.
